q_max_fetch: RTL and testbench

- Upstream operand fetcher for the Q-value update stage.
- On each learning step, it reads the current Q(s,a) from the Q-table RAM, giving old_Q.
- It then scans all actions of the next state s' to find max_a Q(s',a), giving max_Q.
- It presents both values, plus the arg-max action, to the update datapath under a valid/ready handshake.

---
 rtl/q_max_fetch_if.sv | 35 +++
 rtl/q_max_fetch.sv | 124 ++++++++++++
 tb/tb_q_max_fetch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/q_max_fetch_if.sv
// q_max_fetch_if: bundles every non-clock/reset signal of the Q-max operand fetcher.
//   Request:  start, cur_state, cur_action, next_state (in), busy (out)
//   Q-table:  ram_rd_en, ram_addr (out), ram_rdata (in)
//   Result:   old_Q, max_Q, max_action, valid_out (out), ready_in (in)
// The slave modport is the fetcher; the master modport is its environment
// (requester, Q-table RAM and downstream update datapath).
interface q_max_fetch_if #(
   parameter int unsigned STATE_W  = 4,
   parameter int unsigned ACTION_W = 2,
   parameter int unsigned Q_W      = 16
);
   logic                         start;
   logic [STATE_W-1:0]           cur_state;
   logic [ACTION_W-1:0]          cur_action;
   logic [STATE_W-1:0]           next_state;
   logic                         busy;
   logic                         ram_rd_en;
   logic [STATE_W+ACTION_W-1:0]  ram_addr;
   logic [Q_W-1:0]               ram_rdata;
   logic [Q_W-1:0]               old_Q;
   logic [Q_W-1:0]               max_Q;
   logic [ACTION_W-1:0]          max_action;
   logic                         valid_out;
   logic                         ready_in;

   modport master (
      output start, cur_state, cur_action, next_state, ram_rdata, ready_in,
      input  busy, ram_rd_en, ram_addr, old_Q, max_Q, max_action, valid_out
   );

   modport slave (
      input  start, cur_state, cur_action, next_state, ram_rdata, ready_in,
      output busy, ram_rd_en, ram_addr, old_Q, max_Q, max_action, valid_out
   );
endinterface

// File: rtl/q_max_fetch.sv
// q_max_fetch: reads Q(s,a) and scans Q(s',0..NUM_ACTIONS-1) from the Q-table,
// presenting old_Q, max_Q and the arg-max action under a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    q_max_fetch_if.slave (request, Q-table read port, result handshake)
// NUM_ACTIONS must lie in 1..2**ACTION_W.
module q_max_fetch #(
   parameter int unsigned STATE_W     = 4,
   parameter int unsigned ACTION_W    = 2,
   parameter int unsigned NUM_ACTIONS = 4,
   parameter int unsigned Q_W         = 16
) (
   input logic           clk,
   input logic           rst_n,
   q_max_fetch_if.slave  bus
);

   // Counter counts edges since the start edge; wide enough to reach NUM_ACTIONS+1.
   localparam int unsigned CntW = ACTION_W + 2;
   localparam logic [CntW-1:0] LastIssue = CntW'(NUM_ACTIONS - 1);
   localparam logic [CntW-1:0] LastCmp   = CntW'(NUM_ACTIONS + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

   state_e                       state_q, state_d;
   logic [CntW-1:0]              cnt_q;
   logic [STATE_W-1:0]           next_state_q;
   logic                         rd_en_q;
   logic [STATE_W+ACTION_W-1:0]  addr_q;
   logic [Q_W-1:0]               old_q_q;
   logic [Q_W-1:0]               max_q_q;
   logic [ACTION_W-1:0]          max_action_q;
   logic                         scanning;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.start)          state_d = StIssue;
         StIssue: if (cnt_q == LastIssue) state_d = StDrain;
         StDrain: if (cnt_q == LastCmp)   state_d = StHold;
         StHold:  if (bus.ready_in)       state_d = StIdle;
         default:                         state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy      = (state_q != StIdle);
      bus.valid_out = (state_q == StHold);
   end

   assign scanning = (state_q == StIssue) || (state_q == StDrain);

   // Read issue and data capture. Read data for the request issued at edge Ej
   // is present on ram_rdata just before edge E(j+2); with cnt_q == j-1 at Ej,
   // old_Q lands at cnt_q == 1 and action k lands at cnt_q == k+2.
   // s and a are consumed directly at the start edge, so only s' is latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         next_state_q <= '0;
         rd_en_q      <= 1'b0;
         addr_q       <= '0;
         old_q_q      <= '0;
         max_q_q      <= '0;
         max_action_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  next_state_q <= bus.next_state;
                  cnt_q        <= '0;
                  rd_en_q      <= 1'b1;
                  addr_q       <= {bus.cur_state, bus.cur_action};
               end
            end
            StIssue: begin
               rd_en_q <= 1'b1;
               addr_q  <= {next_state_q, cnt_q[ACTION_W-1:0]};
               cnt_q   <= cnt_q + 1'b1;
            end
            StDrain: begin
               rd_en_q <= 1'b0;
               cnt_q   <= cnt_q + 1'b1;
            end
            default: ;
         endcase

         if (scanning) begin
            if (cnt_q == CntW'(1)) begin
               old_q_q <= bus.ram_rdata;
            end
            if (cnt_q == CntW'(2)) begin
               // Action 0 seeds the max so nothing from a previous fetch survives.
               max_q_q      <= bus.ram_rdata;
               max_action_q <= '0;
            end else if ((cnt_q > CntW'(2)) && (cnt_q <= LastCmp) &&
                         ($signed(bus.ram_rdata) > $signed(max_q_q))) begin
               // Strict compare keeps the lowest action index on ties.
               max_q_q      <= bus.ram_rdata;
               max_action_q <= ACTION_W'(cnt_q - CntW'(2));
            end
         end
      end
   end

   assign bus.ram_rd_en  = rd_en_q;
   assign bus.ram_addr   = addr_q;
   assign bus.old_Q      = old_q_q;
   assign bus.max_Q      = max_q_q;
   assign bus.max_action = max_action_q;

endmodule

// File: tb/tb_q_max_fetch.sv
// tb_q_max_fetch: directed self-checking bench for q_max_fetch with a behavioural
// one-cycle-latency Q-table RAM.
module tb_q_max_fetch;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [15:0] mem [64];

   q_max_fetch_if #(.STATE_W(4), .ACTION_W(2), .Q_W(16)) bus ();

   q_max_fetch #(
      .STATE_W    (4),
      .ACTION_W   (2),
      .NUM_ACTIONS(4),
      .Q_W        (16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Q-table: data for the address sampled at an edge is valid after that edge.
   always @(posedge clk) begin
      if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},  32'(bus.busy),       32'd0);
      chk({tag, "_rd_en"}, 32'(bus.ram_rd_en),  32'd0);
      chk({tag, "_addr"},  32'(bus.ram_addr),   32'd0);
      chk({tag, "_old"},   32'(bus.old_Q),      32'd0);
      chk({tag, "_max"},   32'(bus.max_Q),      32'd0);
      chk({tag, "_act"},   32'(bus.max_action), 32'd0);
      chk({tag, "_valid"}, 32'(bus.valid_out),  32'd0);
   endtask

   task automatic begin_fetch(input string tag, input logic [3:0] s, input logic [1:0] a,
                              input logic [3:0] sp);
      bus.cur_state  = s;
      bus.cur_action = a;
      bus.next_state = sp;
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      chk({tag, "_rd_en0"}, 32'(bus.ram_rd_en), 32'd1);
      chk({tag, "_addr0"},  32'(bus.ram_addr),  32'({s, a}));
   endtask

   task automatic wait_result(input string tag, input logic [15:0] eo, input logic [15:0] em,
                              input logic [1:0] ea);
      int cyc = 0;
      do begin
         step();
         cyc++;
      end while (!bus.valid_out && cyc < 20);
      chk({tag, "_latency"}, 32'(cyc),            32'd6);
      chk({tag, "_valid"},   32'(bus.valid_out),  32'd1);
      chk({tag, "_old"},     32'(bus.old_Q),      32'(eo));
      chk({tag, "_max"},     32'(bus.max_Q),      32'(em));
      chk({tag, "_act"},     32'(bus.max_action), 32'(ea));
   endtask

   task automatic handshake(input string tag);
      bus.ready_in = 1'b1;
      step();
      bus.ready_in = 1'b0;
      chk({tag, "_hs_valid"}, 32'(bus.valid_out), 32'd0);
      chk({tag, "_hs_busy"},  32'(bus.busy),      32'd0);
   endtask

   initial begin
      logic [5:0] basic_addr [4];
      basic_addr = '{6'h14, 6'h15, 6'h16, 6'h17};
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      bus.ram_rdata  = '0;
      bus.start      = 1'b0;
      bus.cur_state  = '0;
      bus.cur_action = '0;
      bus.next_state = '0;
      bus.ready_in   = 1'b0;

      // Asynchronous reset before any clock edge.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset("rst_async");
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_busy",  32'(bus.busy),      32'd0);
         chk("idle_rd_en", 32'(bus.ram_rd_en), 32'd0);
      end

      // Basic fetch: s=3, a=1, s'=5.
      mem[6'h0D] = 16'h0040;
      mem[6'h14] = 16'h0010;
      mem[6'h15] = 16'h0120;
      mem[6'h16] = 16'h0030;
      mem[6'h17] = 16'h0100;
      begin_fetch("basic", 4'd3, 2'd1, 4'd5);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("basic_addr",  32'(bus.ram_addr),  32'(basic_addr[i]));
         chk("basic_rd_en", 32'(bus.ram_rd_en), 32'd1);
         chk("basic_busy",  32'(bus.busy),      32'd1);
      end
      step();
      chk("basic_rd_off",    32'(bus.ram_rd_en), 32'd0);
      chk("basic_not_valid", 32'(bus.valid_out), 32'd0);
      step();
      chk("basic_valid", 32'(bus.valid_out),  32'd1);
      chk("basic_old",   32'(bus.old_Q),      32'h0040);
      chk("basic_max",   32'(bus.max_Q),      32'h0120);
      chk("basic_act",   32'(bus.max_action), 32'd1);
      handshake("basic");

      // Signed compare and ties, then back-pressure with an ignored start.
      mem[6'h0B] = 16'h1234;
      mem[6'h1C] = 16'hFFF0;
      mem[6'h1D] = 16'hFFF0;
      mem[6'h1E] = 16'h8000;
      mem[6'h1F] = 16'hFFFF;
      begin_fetch("signed", 4'd2, 2'd3, 4'd7);
      wait_result("signed", 16'h1234, 16'hFFFF, 2'd3);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            bus.cur_state  = 4'hF;
            bus.cur_action = 2'd2;
            bus.next_state = 4'hE;
            bus.start      = 1'b1;
         end
         step();
         bus.start = 1'b0;
         chk("bp_valid", 32'(bus.valid_out),  32'd1);
         chk("bp_old",   32'(bus.old_Q),      32'h1234);
         chk("bp_max",   32'(bus.max_Q),      32'hFFFF);
         chk("bp_act",   32'(bus.max_action), 32'd3);
         chk("bp_rd_en", 32'(bus.ram_rd_en),  32'd0);
      end
      handshake("bp");
      step();
      chk("bp_after_rd_en", 32'(bus.ram_rd_en), 32'd0);
      chk("bp_after_busy",  32'(bus.busy),      32'd0);

      // All-equal scan with s'=s: tie resolves to action 0.
      mem[6'h20] = 16'hFFF0;
      mem[6'h21] = 16'hFFF0;
      mem[6'h22] = 16'hFFF0;
      mem[6'h23] = 16'hFFF0;
      begin_fetch("ties", 4'd8, 2'd2, 4'd8);
      wait_result("ties", 16'hFFF0, 16'hFFF0, 2'd0);

      // Back-to-back: start during the handshake cycle is ignored, then taken
      // in the first IDLE cycle. All values below the previous max.
      mem[6'h04] = 16'h0777;
      mem[6'h24] = 16'h8001;
      mem[6'h25] = 16'h8003;
      mem[6'h26] = 16'h8002;
      mem[6'h27] = 16'h8000;
      bus.cur_state  = 4'd1;
      bus.cur_action = 2'd0;
      bus.next_state = 4'd9;
      bus.start      = 1'b1;
      bus.ready_in   = 1'b1;
      step();
      bus.ready_in = 1'b0;
      chk("b2b_hs_valid", 32'(bus.valid_out), 32'd0);
      chk("b2b_hs_busy",  32'(bus.busy),      32'd0);
      chk("b2b_hs_rd_en", 32'(bus.ram_rd_en), 32'd0);
      step();
      bus.start = 1'b0;
      chk("b2b_rd_en0", 32'(bus.ram_rd_en), 32'd1);
      chk("b2b_addr0",  32'(bus.ram_addr),  32'h04);
      wait_result("b2b", 16'h0777, 16'h8003, 2'd1);
      handshake("b2b");

      // Reset asserted mid-scan (third ISSUE cycle).
      mem[6'h10] = 16'hFFFE;
      mem[6'h28] = 16'h0001;
      mem[6'h29] = 16'h0002;
      mem[6'h2A] = 16'h0003;
      mem[6'h2B] = 16'h0004;
      begin_fetch("abort", 4'd4, 2'd0, 4'd10);
      step();
      step();
      #2 rst_n = 1'b0;
      #1 check_reset("rst_midscan");
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_valid", 32'(bus.valid_out), 32'd0);
         chk("abort_busy",  32'(bus.busy),      32'd0);
      end
      begin_fetch("fresh", 4'd4, 2'd0, 4'd10);
      wait_result("fresh", 16'hFFFE, 16'h0004, 2'd3);
      handshake("fresh");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
